hash_arbiter: RTL and testbench

Round-robin scheduler that shares the single H hash unit (SHA3 over 1088-bit blocks) between several requesters, e.g. the H1 seed-set hasher and the H3 commitment hasher.
- Registers a grant and muxes the winner's mode, block count and message onto the H inputs.
- Sequences H's sticky `en_end` / `restart` handshake.
- Returns the 512-bit digest to the winner with a one-cycle done pulse.
- Includes a watchdog against a hung hash core.

---
 rtl/hash_pkg.sv | 11 +
 rtl/rr_pick.sv | 30 +++
 rtl/hash_arbiter.sv | 144 ++++++++++++++
 tb/tb_hash_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/hash_pkg.sv
// hash_pkg: widths, mode codes and arbiter FSM states shared by the H hash unit
// and the blocks that drive it.
package hash_pkg;
    localparam int H_BLK_W  = 1088;
    localparam int DIGEST_W = 512;
    localparam int MODE_W   = 4;
    localparam int GROUP_W  = 10;
    localparam logic [MODE_W-1:0] MODE_SEED   = 4'd0;
    localparam logic [MODE_W-1:0] MODE_COMMIT = 4'd1;
    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; first requester at or after ptr_i,
// wrapping modulo NREQ, returned both one-hot and as an index.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic            any_o,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);
    logic [IW:0] k;
    // Scan from farthest to nearest so the candidate closest to ptr_i wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        k = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = {1'b0, ptr_i} + (IW+1)'(i);
            k = (k >= (IW+1)'(NREQ)) ? k - (IW+1)'(NREQ) : k;
            if (req_i[k[IW-1:0]]) begin
                gnt_o = '0;
                gnt_o[k[IW-1:0]] = 1'b1;
                idx_o = k[IW-1:0];
            end
        end
    end
    assign any_o = |req_i;
endmodule

// File: rtl/hash_arbiter.sv
// hash_arbiter: round-robin sharing of the single H hash core between NREQ
// requesters, sequencing its start/restart handshake under a watchdog.
module hash_arbiter
    import hash_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MSG_W   = 2176,
    parameter int TIMEOUT = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_i,
    input  logic [MODE_W*NREQ-1:0]  req_mode_i,
    input  logic [GROUP_W*NREQ-1:0] req_group_i,
    input  logic [MSG_W*NREQ-1:0]   req_msg_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [NREQ-1:0]         done_o,
    output logic                    err_o,
    output logic [DIGEST_W-1:0]     digest_o,
    output logic                    busy_o,
    output logic                    timeout_o,
    output logic                    h_start_o,
    output logic                    h_restart_o,
    output logic [MODE_W-1:0]       h_mode_o,
    output logic [GROUP_W-1:0]      h_group_o,
    output logic [MSG_W-1:0]        h_msg_o,
    input  logic [DIGEST_W-1:0]     h_hash_i,
    input  logic                    h_en_end_i
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    logic [MODE_W-1:0]  mode_a  [NREQ];
    logic [GROUP_W-1:0] group_a [NREQ];
    logic [MSG_W-1:0]   msg_a   [NREQ];
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign mode_a[i]  = req_mode_i[i*MODE_W +: MODE_W];
        assign group_a[i] = req_group_i[i*GROUP_W +: GROUP_W];
        assign msg_a[i]   = req_msg_i[i*MSG_W +: MSG_W];
    end

    arb_state_e          state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [IW-1:0]       rr_q, rr_d;
    logic                err_q, err_d;
    logic                tmo_q, tmo_d;
    logic                phase_q, phase_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DIGEST_W-1:0] digest_q, digest_d;

    logic            pick_any;
    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i (req_i),
        .ptr_i (rr_q),
        .any_o (pick_any),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    // An illegal-mode job still walks through START (with H pins held idle) so
    // its error done lands two cycles after the grant, like a real launch would.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        idx_d    = idx_q;
        rr_d     = rr_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        phase_d  = 1'b0;
        cnt_d    = cnt_q;
        digest_d = digest_q;
        case (state_q)
            IDLE: if (pick_any) begin
                state_d = START;
                gnt_d   = pick_gnt;
                idx_d   = pick_idx;
                err_d   = mode_a[pick_idx] > MODE_COMMIT;
                cnt_d   = '0;
            end
            START: begin
                phase_d = ~phase_q;
                state_d = !phase_q ? START : (err_q ? DONE : WAIT);
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (h_en_end_i) begin
                    digest_d = h_hash_i;
                    err_d    = 1'b0;
                    state_d  = DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                rr_d    = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            idx_q    <= '0;
            rr_q     <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
            phase_q  <= 1'b0;
            cnt_q    <= '0;
            digest_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            idx_q    <= idx_d;
            rr_q     <= rr_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            digest_q <= digest_d;
        end
    end

    assign busy_o      = state_q != IDLE;
    assign gnt_o       = gnt_q;
    assign done_o      = (state_q == DONE) ? gnt_q : '0;
    assign err_o       = (state_q == DONE) && err_q;
    assign digest_o    = digest_q;
    assign timeout_o   = tmo_q;
    assign h_start_o   = (state_q == START) && !err_q;
    assign h_restart_o = h_start_o;
    assign h_mode_o    = busy_o ? mode_a[idx_q] : '0;
    assign h_group_o   = busy_o ? group_a[idx_q] : '0;
    assign h_msg_o     = busy_o ? msg_a[idx_q] : '0;
endmodule

// File: tb/tb_hash_arbiter.sv
// tb_hash_arbiter: directed bench for hash_arbiter with a behavioural H core
// whose en_end stays set until the next restart.
module tb_hash_arbiter;
    localparam int NREQ = 4;
    localparam int MSG_W = 2176;
    localparam int TMO = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [3:0] mode [NREQ];
    logic [9:0] group [NREQ];
    logic [MSG_W-1:0] msg [NREQ];
    logic [4*NREQ-1:0] req_mode;
    logic [10*NREQ-1:0] req_group;
    logic [MSG_W*NREQ-1:0] req_msg;
    logic [NREQ-1:0] gnt, done;
    logic err, busy, tmo, h_start, h_restart;
    logic [511:0] digest;
    logic [3:0] h_mode;
    logic [9:0] h_group;
    logic [MSG_W-1:0] h_msg;

    logic en_end = 1'b0;
    logic armed = 1'b0;
    int mcnt = 0;
    int lat = 0;
    logic [511:0] hv = '0;
    logic [511:0] hash = '0;

    int checks = 0;
    int errors = 0;
    int n;
    logic [NREQ-1:0] exp_g [4];

    always #5 clk = ~clk;

    assign req_mode  = {mode[3], mode[2], mode[1], mode[0]};
    assign req_group = {group[3], group[2], group[1], group[0]};
    assign req_msg   = {msg[3], msg[2], msg[1], msg[0]};

    hash_arbiter #(.NREQ(NREQ), .MSG_W(MSG_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req_i(req), .req_mode_i(req_mode),
        .req_group_i(req_group), .req_msg_i(req_msg), .gnt_o(gnt),
        .done_o(done), .err_o(err), .digest_o(digest), .busy_o(busy),
        .timeout_o(tmo), .h_start_o(h_start), .h_restart_o(h_restart),
        .h_mode_o(h_mode), .h_group_o(h_group), .h_msg_o(h_msg),
        .h_hash_i(hash), .h_en_end_i(en_end)
    );

    // H model: restart clears en_end and reloads the latency; en_end rises lat+1 cycles after the last restart cycle.
    always @(posedge clk) begin
        if (h_restart) begin
            en_end <= 1'b0;
            armed  <= 1'b1;
            mcnt   <= lat;
        end else if (armed) begin
            if (mcnt == 0) begin
                en_end <= 1'b1;
                hash   <= hv;
                armed  <= 1'b0;
            end else mcnt <= mcnt - 1;
        end
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done == '0 && cyc < 200) begin
            tick();
            cyc++;
        end
        if (done == '0) check("done_wait", 0, 1);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            msg[i] = {32'hF00D_0000 + i, {67{32'hC0DE_0000 + i}}};
            group[i] = 10'(i + 1);
        end
        mode[0] = 4'd0; mode[1] = 4'd1; mode[2] = 4'd5; mode[3] = 4'd0;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b1000; exp_g[3] = 4'b0001;

        tick();
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_tmo", tmo, 0);
        check("rst_start", h_start, 0);
        check("rst_digest", digest, 0);
        check("rst_hmsg", h_msg[511:0], 0);
        reset = 1'b0;
        tick();

        // single job on requester 0
        lat = 20; hv = {64{8'hA5}}; req = 4'b0001;
        tick();
        check("j1_gnt", gnt, 4'b0001);
        check("j1_busy", busy, 1);
        check("j1_start1", h_start, 1);
        check("j1_restart1", h_restart, 1);
        check("j1_mode", h_mode, 0);
        check("j1_group", h_group, 1);
        check("j1_msg_lo", h_msg[31:0], 32'hC0DE_0000);
        check("j1_msg_hi", h_msg[MSG_W-1 -: 32], 32'hF00D_0000);
        tick();
        check("j1_start2", h_start, 1);
        tick();
        check("j1_start3", h_start, 0);
        wait_done(n);
        check("j1_lat", n, 22);
        check("j1_done", done, 4'b0001);
        check("j1_err", err, 0);
        check("j1_digest", digest, {64{8'hA5}});
        req = '0;
        tick();
        check("j1_idle_done", done, 0);
        check("j1_idle_busy", busy, 0);
        check("j1_idle_gnt", gnt, 0);
        check("j1_idle_mode", h_mode, 0);
        check("j1_hold_digest", digest, {64{8'hA5}});

        // stale en_end from previous job must not end this one
        check("stale_pre", en_end, 1);
        lat = 5; hv = {64{8'h3C}}; req = 4'b0010;
        tick();
        check("st_gnt", gnt, 4'b0010);
        check("st_mode", h_mode, 1);
        tick();
        check("st_done_c2", done, 0);
        tick();
        check("st_done_c3", done, 0);
        wait_done(n);
        check("st_lat", n, 7);
        check("st_done", done, 4'b0010);
        check("st_digest", digest, {64{8'h3C}});
        req = '0;
        tick();

        // illegal mode on requester 2
        req = 4'b0100;
        tick();
        check("il_gnt", gnt, 4'b0100);
        check("il_start1", h_start, 0);
        tick();
        check("il_start2", h_start, 0);
        check("il_done_early", done, 0);
        tick();
        check("il_done", done, 4'b0100);
        check("il_err", err, 1);
        check("il_digest", digest, {64{8'h3C}});
        check("il_tmo", tmo, 0);
        req = '0;
        tick();
        check("il_idle", busy, 0);

        // watchdog timeout on requester 3
        lat = 1000; req = 4'b1000;
        tick();
        check("to_gnt", gnt, 4'b1000);
        tick();
        tick();
        wait_done(n);
        check("to_lat", n, TMO);
        check("to_done", done, 4'b1000);
        check("to_err", err, 1);
        check("to_flag", tmo, 1);
        check("to_digest", digest, {64{8'h3C}});
        req = '0;
        tick();

        // contention 1011 held: grants 0,1,3,0
        lat = 3; req = 4'b1011;
        for (int j = 0; j < 4; j++) begin
            hv = {64{8'(8'h10 + j)}};
            tick();
            check("rr_gnt", gnt, exp_g[j]);
            wait_done(n);
            check("rr_done", done, exp_g[j]);
            check("rr_err", err, 0);
            check("rr_tmo_sticky", tmo, 1);
            check("rr_digest", digest, {64{8'(8'h10 + j)}});
            if (j == 3) req = '0;
            tick();
            check("rr_gap_gnt", gnt, 0);
            check("rr_gap_busy", busy, 0);
        end

        // asynchronous reset during WAIT
        lat = 1000; req = 4'b0010;
        tick();
        check("rs_gnt", gnt, 4'b0010);
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        check("rs_gnt0", gnt, 0);
        check("rs_busy0", busy, 0);
        check("rs_digest0", digest, 0);
        check("rs_tmo0", tmo, 0);
        check("rs_mode0", h_mode, 0);
        tick();
        reset = 1'b0; lat = 2; hv = {64{8'h5A}}; req = 4'b1001;
        tick();
        check("rs_ptr0", gnt, 4'b0001);
        wait_done(n);
        check("rs_lat", n, 6);
        check("rs_done", done, 4'b0001);
        check("rs_digest", digest, {64{8'h5A}});
        req = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
